// File: rtl/ysyx_22040895_mdu_issue.sv
// ----------------------------------------------------------------------------
// ysyx_22040895_mdu_issue
//   Issue/sequencing stage placed between ID and EX/WB for the RV64M ops that
//   the combinational multiply/divide unit (ysyx_22040895_mdu, also in this
//   file) supports. The stage works as follows:
//     - It accepts one op per valid/ready handshake.
//     - It decodes funct3 and the word flag to a 4-bit mduop.
//     - It registers the operands and models a fixed per-op latency.
//     - It then holds the result until WB takes it.
//
//   Parameters
//     MUL_LAT  cycles from accept to out_valid for mul/mulw   (1..15)
//     DIV_LAT  cycles from accept to out_valid for divw/remw  (1..15)
//
//   Ports
//     clk, rst_n        rising-edge clock, asynchronous active-low reset
//     flush_i           synchronous flush; kills held, in-flight or offered op
//     in_valid_i        ID offers an op
//     in_ready_o        stage can take the op this cycle
//     funct3_i          funct3 of the instruction
//     is_word_i         1 = OP-32 (W-form), 0 = OP
//     op1_i, op2_i      rs1 / rs2 values
//     rd_i              destination register
//     out_valid_o       result valid toward WB
//     out_ready_i       WB accepts the result
//     out_result_o      64-bit result
//     out_rd_o          destination register of the result
//     out_illeg_o       op was not supported; out_result_o is 0
//
//   Build option
//     MDU_DIVZERO_FIX_EN  When this is defined, divw/remw by zero return the
//                         RISC-V results:
//                           - divw returns all ones.
//                           - remw returns the sign-extended dividend.
//                         These fixed values bypass the mdu, but the op still
//                         takes DIV_LAT cycles.
//                         When it is undefined, the raw mdu value passes
//                         through unchanged.
// ----------------------------------------------------------------------------

// ----------------------------------------------------------------------------
// ysyx_22040895_mdu
//   Purely combinational RV64M datapath. It serves four ops:
//     - mul:  low 64 bits of the product.
//     - mulw: low 32 bits of the product, sign-extended.
//     - divw: signed 32-bit quotient, sign-extended.
//     - remw: signed 32-bit remainder, sign-extended.
//   Any other mduop returns 0.
//   For a divisor of zero, the raw unit returns 0.
//   For the overflow case (INT32_MIN / -1), it returns INT32_MIN as the
//   quotient and 0 as the remainder.
//
//   Ports
//     mduop   4-bit op code produced by the issue stage
//     op1     first operand
//     op2     second operand
//     result  64-bit result
// ----------------------------------------------------------------------------
module ysyx_22040895_mdu (
  input  logic [3:0]  mduop,
  input  logic [63:0] op1,
  input  logic [63:0] op2,
  output logic [63:0] result
);

  logic signed [31:0] a;
  logic signed [31:0] b;
  logic [63:0]        mul_lo;
  logic [31:0]        mulw_lo;
  logic [31:0]        quo;
  logic [31:0]        rem;

  // NOTE: every variable written in an always_comb block gets a default value
  // first. Without it, a path that skips an assignment would infer a latch.
  always_comb begin
    a       = op1[31:0];
    b       = op2[31:0];
    mul_lo  = op1 * op2;
    mulw_lo = op1[31:0] * op2[31:0];
    quo     = '0;
    rem     = '0;
    if (b == 32'sd0) begin
      quo = '0;
      rem = '0;
    end else if (a == 32'sh8000_0000 && b == -32'sd1) begin
      quo = a;
      rem = '0;
    end else begin
      quo = a / b;
      rem = a % b;
    end

    unique case (mduop)
      4'b0001: result = mul_lo;
      4'b0101: result = {{32{mulw_lo[31]}}, mulw_lo};
      4'b1001: result = {{32{quo[31]}}, quo};
      4'b1101: result = {{32{rem[31]}}, rem};
      default: result = '0;
    endcase
  end

endmodule

module ysyx_22040895_mdu_issue #(
  parameter int MUL_LAT = 1,
  parameter int DIV_LAT = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        flush_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [2:0]  funct3_i,
  input  logic        is_word_i,
  input  logic [63:0] op1_i,
  input  logic [63:0] op2_i,
  input  logic [4:0]  rd_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [63:0] out_result_o,
  output logic [4:0]  out_rd_o,
  output logic        out_illeg_o
);

  localparam logic [3:0] OP_NONE = 4'b0000;
  localparam logic [3:0] OP_MUL  = 4'b0001;
  localparam logic [3:0] OP_MULW = 4'b0101;
  localparam logic [3:0] OP_DIVW = 4'b1001;
  localparam logic [3:0] OP_REMW = 4'b1101;

  localparam logic [3:0] MUL_L = MUL_LAT[3:0];
  localparam logic [3:0] DIV_L = DIV_LAT[3:0];

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;

  // Operands and attributes of the accepted op
  logic [3:0]  mduop_q;
  logic [63:0] op1_q;
  logic [63:0] op2_q;
  logic [4:0]  rd_q;
  logic        illeg_q;

  // Values presented to WB
  logic [63:0] result_q;
  logic [4:0]  out_rd_q;
  logic        out_illeg_q;

  // Decode of the op currently offered by ID
  logic [3:0]  dec_op;
  logic        dec_illeg;
  logic [3:0]  dec_lat;

  logic        accept;
  logic        done_entry;

  // Operand path into the mdu
  logic [3:0]  sel_op;
  logic [63:0] sel_op1;
  logic [63:0] sel_op2;
  logic [4:0]  sel_rd;
  logic        sel_illeg;
  logic [63:0] mdu_result;
  logic [63:0] final_result;

  always_comb begin
    dec_op    = OP_NONE;
    dec_illeg = 1'b1;
    dec_lat   = 4'd1;
    unique case ({is_word_i, funct3_i})
      4'b0_000: begin dec_op = OP_MUL;  dec_illeg = 1'b0; dec_lat = MUL_L; end
      4'b1_000: begin dec_op = OP_MULW; dec_illeg = 1'b0; dec_lat = MUL_L; end
      4'b1_100: begin dec_op = OP_DIVW; dec_illeg = 1'b0; dec_lat = DIV_L; end
      4'b1_110: begin dec_op = OP_REMW; dec_illeg = 1'b0; dec_lat = DIV_L; end
      default:  ;
    endcase
  end

  assign in_ready_o = ~flush_i &
                      ((state_q == IDLE) | ((state_q == DONE) & out_ready_i));
  assign accept     = in_valid_i & in_ready_o;

  // A single-cycle op enters DONE on its own accept edge, so at that moment
  // the mdu must see the incoming op rather than the stale latched one.
  // When DONE is entered from BUSY, no accept is possible, and the mdu sees
  // the latched op.
  assign sel_op    = accept ? dec_op    : mduop_q;
  assign sel_op1   = accept ? op1_i     : op1_q;
  assign sel_op2   = accept ? op2_i     : op2_q;
  assign sel_rd    = accept ? rd_i      : rd_q;
  assign sel_illeg = accept ? dec_illeg : illeg_q;

  ysyx_22040895_mdu u_mdu (
    .mduop  (sel_op),
    .op1    (sel_op1),
    .op2    (sel_op2),
    .result (mdu_result)
  );

`ifdef MDU_DIVZERO_FIX_EN
  always_comb begin
    final_result = mdu_result;
    if (sel_op == OP_DIVW && sel_op2[31:0] == 32'd0) begin
      final_result = '1;
    end else if (sel_op == OP_REMW && sel_op2[31:0] == 32'd0) begin
      final_result = {{32{sel_op1[31]}}, sel_op1[31:0]};
    end
  end
`else
  assign final_result = mdu_result;
`endif

  // Next-state logic. A flush takes priority over every other event.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    done_entry = 1'b0;
    if (flush_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept) begin
            cnt_d = dec_lat - 4'd1;
            if (dec_lat == 4'd1) begin
              state_d    = DONE;
              done_entry = 1'b1;
            end else begin
              state_d = BUSY;
            end
          end
        end
        BUSY: begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) begin
            state_d    = DONE;
            done_entry = 1'b1;
          end
        end
        DONE: begin
          if (out_ready_i) begin
            if (accept) begin
              cnt_d = dec_lat - 4'd1;
              if (dec_lat == 4'd1) begin
                state_d    = DONE;
                done_entry = 1'b1;
              end else begin
                state_d = BUSY;
              end
            end else begin
              state_d = IDLE;
            end
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  // NOTE: sequential state uses non-blocking (<=) assignments so every
  // register samples its pre-edge value, whatever order the blocks run in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // NOTE: the datapath registers are reset too, even though their contents
  // only matter after an accept. This makes the outputs read 0 out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mduop_q     <= OP_NONE;
      op1_q       <= '0;
      op2_q       <= '0;
      rd_q        <= '0;
      illeg_q     <= 1'b0;
      result_q    <= '0;
      out_rd_q    <= '0;
      out_illeg_q <= 1'b0;
    end else begin
      if (accept) begin
        mduop_q <= dec_op;
        op1_q   <= op1_i;
        op2_q   <= op2_i;
        rd_q    <= rd_i;
        illeg_q <= dec_illeg;
      end
      if (done_entry) begin
        result_q    <= final_result;
        out_rd_q    <= sel_rd;
        out_illeg_q <= sel_illeg;
      end
    end
  end

  assign out_valid_o  = (state_q == DONE);
  assign out_result_o = result_q;
  assign out_rd_o     = out_rd_q;
  assign out_illeg_o  = out_illeg_q;

endmodule

// File: tb/tb_ysyx_22040895_mdu_issue.sv
// ----------------------------------------------------------------------------
// tb_ysyx_22040895_mdu_issue
//   Directed bench for the M-extension issue stage, using the default
//   latencies (MUL_LAT=1, DIV_LAT=4).
//   Inputs are driven on the falling edge, and outputs are sampled on the
//   falling edge.
//   Latency is the number of falling edges from the accept edge up to and
//   including the first one where out_valid is high.
// ----------------------------------------------------------------------------
module tb_ysyx_22040895_mdu_issue;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush_i;
  logic        in_valid_i;
  logic        in_ready_o;
  logic [2:0]  funct3_i;
  logic        is_word_i;
  logic [63:0] op1_i;
  logic [63:0] op2_i;
  logic [4:0]  rd_i;
  logic        out_valid_o;
  logic        out_ready_i;
  logic [63:0] out_result_o;
  logic [4:0]  out_rd_o;
  logic        out_illeg_o;

  int pass_cnt = 0;
  int total_cnt = 0;

  always #5 clk = ~clk;

  ysyx_22040895_mdu_issue dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .flush_i      (flush_i),
    .in_valid_i   (in_valid_i),
    .in_ready_o   (in_ready_o),
    .funct3_i     (funct3_i),
    .is_word_i    (is_word_i),
    .op1_i        (op1_i),
    .op2_i        (op2_i),
    .rd_i         (rd_i),
    .out_valid_o  (out_valid_o),
    .out_ready_i  (out_ready_i),
    .out_result_o (out_result_o),
    .out_rd_o     (out_rd_o),
    .out_illeg_o  (out_illeg_o)
  );

  // Offers one op for a single clock edge, then scrambles the inputs so that
  // a result still depending on them would come out wrong.
  task automatic issue(input logic w, input logic [2:0] f3,
                       input logic [63:0] a, input logic [63:0] b,
                       input logic [4:0] rd);
    @(negedge clk);
    is_word_i  = w;
    funct3_i   = f3;
    op1_i      = a;
    op2_i      = b;
    rd_i       = rd;
    in_valid_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    op1_i      = 64'hDEAD_BEEF_0BAD_F00D;
    op2_i      = 64'h0123_4567_89AB_CDEF;
    rd_i       = 5'd31;
  endtask

  // Returns the latency in falling edges, or 0 if out_valid never rises within
  // the budget. Also reports whether in_ready was seen high before out_valid.
  task automatic wait_valid(output int n, output logic ready_seen);
    n = 0;
    ready_seen = 1'b0;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (out_valid_o) begin
        n = i;
        break;
      end
      if (in_ready_o) ready_seen = 1'b1;
    end
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush_i = 1'b0; in_valid_i = 1'b0; out_ready_i = 1'b0;
    funct3_i = '0; is_word_i = 1'b0; op1_i = '0; op2_i = '0; rd_i = '0;
    repeat (2) @(negedge clk);
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", out_valid_o); else pass_cnt++;
    total_cnt++; if (out_result_o !== 64'd0) $display("FAIL reset_result got %h want 0", out_result_o); else pass_cnt++;
    total_cnt++; if (out_rd_o !== 5'd0 || out_illeg_o !== 1'b0) $display("FAIL reset_rd_illeg got %0d/%b want 0/0", out_rd_o, out_illeg_o); else pass_cnt++;
    total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL reset_ready got %b want 1", in_ready_o); else pass_cnt++;
    rst_n = 1'b1;
  endtask

  task automatic test_mul();
    int n; logic rs;
    out_ready_i = 1'b1;
    issue(1'b0, 3'b000, 64'd3, 64'd7, 5'd5);
    wait_valid(n, rs);
    total_cnt++; if (n !== 1) $display("FAIL mul_latency got %0d want 1", n); else pass_cnt++;
    total_cnt++; if (out_result_o !== 64'd21) $display("FAIL mul_result got %h want 21", out_result_o); else pass_cnt++;
    total_cnt++; if (out_rd_o !== 5'd5 || out_illeg_o !== 1'b0) $display("FAIL mul_rd got %0d/%b want 5/0", out_rd_o, out_illeg_o); else pass_cnt++;
    drain();
    issue(1'b0, 3'b000, 64'h1_0000_0001, 64'h1_0000_0001, 5'd6);
    wait_valid(n, rs);
    total_cnt++; if (out_result_o !== 64'h0000_0002_0000_0001) $display("FAIL mul64_result got %h want 0000000200000001", out_result_o); else pass_cnt++;
    drain();
    issue(1'b1, 3'b000, 64'hFFFF_FFFF_0000_0003, 64'h0000_0001_0000_0005, 5'd8);
    wait_valid(n, rs);
    total_cnt++; if (out_result_o !== 64'd15) $display("FAIL mulw_hi_ignored got %h want f", out_result_o); else pass_cnt++;
    drain();
  endtask

  task automatic test_divw();
    logic [2:0]  f3  [6] = '{3'b100, 3'b100, 3'b110, 3'b110, 3'b100, 3'b100};
    logic [63:0] a   [6] = '{64'd100, 64'hFFFF_FFFF_FFFF_FF9C, 64'd100,
                             64'hFFFF_FFFF_FFFF_FF9C, 64'h0000_0000_8000_0000,
                             64'h1234_5678_0000_0010};
    logic [63:0] b   [6] = '{64'd7, 64'd7, 64'd7, 64'd7, 64'hFFFF_FFFF_FFFF_FFFF,
                             64'hFFFF_0000_0000_0004};
    logic [63:0] exp [6] = '{64'd14, 64'hFFFF_FFFF_FFFF_FFF2, 64'd2,
                             64'hFFFF_FFFF_FFFF_FFFE, 64'hFFFF_FFFF_8000_0000, 64'd4};
    int n; logic rs;
    out_ready_i = 1'b1;
    for (int i = 0; i < 6; i++) begin
      issue(1'b1, f3[i], a[i], b[i], 5'(10 + i));
      wait_valid(n, rs);
      total_cnt++; if (n !== 4) $display("FAIL div%0d_latency got %0d want 4", i, n); else pass_cnt++;
      total_cnt++; if (rs !== 1'b0) $display("FAIL div%0d_ready_busy got %b want 0", i, rs); else pass_cnt++;
      total_cnt++; if (out_result_o !== exp[i] || out_rd_o !== 5'(10 + i))
        $display("FAIL div%0d_result got %h/%0d want %h/%0d", i, out_result_o, out_rd_o, exp[i], 10 + i);
      else pass_cnt++;
      drain();
    end
  endtask

  task automatic test_back_to_back();
    int n; logic rs; logic stable;
    out_ready_i = 1'b0;
    issue(1'b1, 3'b000, 64'h0000_0000_8000_0000, 64'd1, 5'd3);
    wait_valid(n, rs);
    total_cnt++; if (n !== 1 || out_result_o !== 64'hFFFF_FFFF_8000_0000)
      $display("FAIL mulw_sext got %0d/%h want 1/ffffffff80000000", n, out_result_o);
    else pass_cnt++;
    stable = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (out_valid_o !== 1'b1 || out_result_o !== 64'hFFFF_FFFF_8000_0000 || out_rd_o !== 5'd3)
        stable = 1'b0;
    end
    total_cnt++; if (stable !== 1'b1) $display("FAIL hold_stable got %b want 1", stable); else pass_cnt++;
    out_ready_i = 1'b1;
    is_word_i = 1'b0; funct3_i = 3'b000; op1_i = 64'd6; op2_i = 64'd7; rd_i = 5'd4;
    in_valid_i = 1'b1;
    #1;
    total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL b2b_ready got %b want 1", in_ready_o); else pass_cnt++;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid_o !== 1'b1 || out_result_o !== 64'd42 || out_rd_o !== 5'd4)
      $display("FAIL b2b_result got %b/%h/%0d want 1/2a/4", out_valid_o, out_result_o, out_rd_o);
    else pass_cnt++;
    @(negedge clk);
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL b2b_drain got %b want 0", out_valid_o); else pass_cnt++;
  endtask

  task automatic test_illegal();
    int n; logic rs;
    out_ready_i = 1'b1;
    issue(1'b1, 3'b001, 64'd5, 64'd6, 5'd7);
    wait_valid(n, rs);
    total_cnt++; if (n !== 1 || out_illeg_o !== 1'b1 || out_result_o !== 64'd0 || out_rd_o !== 5'd7)
      $display("FAIL illeg_w001 got %0d/%b/%h/%0d want 1/1/0/7", n, out_illeg_o, out_result_o, out_rd_o);
    else pass_cnt++;
    drain();
    issue(1'b0, 3'b100, 64'd50, 64'd5, 5'd9);
    wait_valid(n, rs);
    total_cnt++; if (n !== 1 || out_illeg_o !== 1'b1 || out_result_o !== 64'd0)
      $display("FAIL illeg_div64 got %0d/%b/%h want 1/1/0", n, out_illeg_o, out_result_o);
    else pass_cnt++;
    drain();
  endtask

  task automatic test_flush();
    logic seen;
    out_ready_i = 1'b1;
    issue(1'b1, 3'b100, 64'd50, 64'd5, 5'd2);
    @(negedge clk);
    flush_i = 1'b1;
    #1;
    total_cnt++; if (in_ready_o !== 1'b0) $display("FAIL flush_ready got %b want 0", in_ready_o); else pass_cnt++;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (out_valid_o) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL flush_busy_valid got %b want 0", seen); else pass_cnt++;
    total_cnt++; if (in_ready_o !== 1'b1) $display("FAIL flush_idle_ready got %b want 1", in_ready_o); else pass_cnt++;
    is_word_i = 1'b0; funct3_i = 3'b000; op1_i = 64'd2; op2_i = 64'd2; rd_i = 5'd1;
    in_valid_i = 1'b1;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    in_valid_i = 1'b0;
    flush_i = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (out_valid_o) seen = 1'b1;
    end
    total_cnt++; if (seen !== 1'b0) $display("FAIL flush_drop_valid got %b want 0", seen); else pass_cnt++;
    out_ready_i = 1'b0;
    issue(1'b0, 3'b000, 64'd6, 64'd7, 5'd12);
    @(negedge clk);
    total_cnt++; if (out_valid_o !== 1'b1) $display("FAIL flush_done_pre got %b want 1", out_valid_o); else pass_cnt++;
    flush_i = 1'b1;
    @(posedge clk);
    #1;
    flush_i = 1'b0;
    @(negedge clk);
    total_cnt++; if (out_valid_o !== 1'b0) $display("FAIL flush_done_valid got %b want 0", out_valid_o); else pass_cnt++;
  endtask

  task automatic test_reset_mid_busy();
    int n; logic rs;
    out_ready_i = 1'b1;
    issue(1'b1, 3'b100, 64'd100, 64'd7, 5'd13);
    @(negedge clk);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total_cnt++; if (out_valid_o !== 1'b0 || out_result_o !== 64'd0 || out_rd_o !== 5'd0 || out_illeg_o !== 1'b0)
      $display("FAIL rst_mid got %b/%h/%0d/%b want 0/0/0/0", out_valid_o, out_result_o, out_rd_o, out_illeg_o);
    else pass_cnt++;
    @(negedge clk);
    rst_n = 1'b1;
    issue(1'b1, 3'b000, 64'd3, 64'hFFFF_FFFE, 5'd14);
    wait_valid(n, rs);
    total_cnt++; if (n !== 1 || out_result_o !== 64'hFFFF_FFFF_FFFF_FFFA || out_rd_o !== 5'd14)
      $display("FAIL rst_after got %0d/%h/%0d want 1/fffffffffffffffa/14", n, out_result_o, out_rd_o);
    else pass_cnt++;
    drain();
  endtask

`ifdef MDU_DIVZERO_FIX_EN
  task automatic test_divzero();
    int n; logic rs;
    out_ready_i = 1'b1;
    issue(1'b1, 3'b100, 64'd12345, 64'hFFFF_FFFF_0000_0000, 5'd20);
    wait_valid(n, rs);
    total_cnt++; if (n !== 4 || out_result_o !== 64'hFFFF_FFFF_FFFF_FFFF)
      $display("FAIL divz_divw got %0d/%h want 4/ffffffffffffffff", n, out_result_o);
    else pass_cnt++;
    drain();
    issue(1'b1, 3'b110, 64'h0000_0000_FFFF_FFF5, 64'd0, 5'd21);
    wait_valid(n, rs);
    total_cnt++; if (n !== 4 || out_result_o !== 64'hFFFF_FFFF_FFFF_FFF5)
      $display("FAIL divz_remw got %0d/%h want 4/fffffffffffffff5", n, out_result_o);
    else pass_cnt++;
    drain();
  endtask
`endif

  initial begin
    test_reset();
    test_mul();
    test_divw();
    test_back_to_back();
    test_illegal();
    test_flush();
    test_reset_mid_busy();
`ifdef MDU_DIVZERO_FIX_EN
    test_divzero();
`endif
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
